// File: rtl/led_matrix_column_scanner.sv
// led_matrix_column_scanner: time-multiplexes a 5x7 irrigation status LED matrix,
// one column at a time, with a blanking gap before every column.
//
// Ports:
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   irrigation_status live status code, sampled once per frame
//   col_rows          column row images from the decoders, column k at [7k+6:7k]
//   status_latched    frame-stable status code fed to the column decoders
//   columns           active-low column enables, at most one low
//   rows              active-high row drive
//   frame_done        one-cycle pulse on the last DRIVE cycle of column 4
//
// Optional feature: define IRRIGATION_BLINK_EN to blink the display while the
// latched status is 2'b11, toggling every BLINK_FRAMES frames.
module led_matrix_column_scanner #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter int BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  irrigation_status,
    input  logic [34:0] col_rows,
    output logic [1:0]  status_latched,
    output logic [4:0]  columns,
    output logic [6:0]  rows,
    output logic        frame_done
);
    localparam int MAXP = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

    if (CLK_DIV < 1 || BLANK_CYCLES < 1 || BLINK_FRAMES < 1) begin : g_bad_params
        $error("led_matrix_column_scanner: CLK_DIV, BLANK_CYCLES and BLINK_FRAMES must be >= 1");
    end

    typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt, next_cnt;
    logic [2:0]      col_idx, next_col;
    logic            last;
    logic            capture;
    logic            blank_rows;
    logic [4:0]      columns_d;
    logic [6:0]      rows_d;
    logic            frame_done_d;
    logic [4:0][6:0] images;

    assign images = col_rows;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BLANK;
            cnt            <= '0;
            col_idx        <= '0;
            columns        <= 5'h1f;
            rows           <= '0;
            frame_done     <= 1'b0;
            status_latched <= 2'b00;
        end else begin
            state          <= next_state;
            cnt            <= next_cnt;
            col_idx        <= next_col;
            columns        <= columns_d;
            rows           <= rows_d;
            frame_done     <= frame_done_d;
            status_latched <= capture ? irrigation_status : status_latched;
        end
    end

    always_comb begin
        last       = (state == BLANK) ? (cnt == CW'(BLANK_CYCLES - 1)) : (cnt == CW'(CLK_DIV - 1));
        next_state = last ? ((state == BLANK) ? DRIVE : BLANK) : state;
        next_cnt   = last ? '0 : cnt + 1'b1;
        next_col   = (last && state == DRIVE) ? ((col_idx == 3'd4) ? 3'd0 : col_idx + 3'd1) : col_idx;
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_comb begin
        capture      = (state == BLANK) && (col_idx == 3'd0) && (cnt == '0);
        columns_d    = (next_state == DRIVE) ? ~(5'd1 << next_col) : 5'h1f;
        rows_d       = (next_state == DRIVE && !blank_rows) ? images[next_col] : 7'd0;
        frame_done_d = (next_state == DRIVE) && (next_col == 3'd4) && (next_cnt == CW'(CLK_DIV - 1));
    end

`ifdef IRRIGATION_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt;
    logic          blink;
    logic          wrap;

    assign wrap = (frame_cnt == FW'(BLINK_FRAMES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            blink     <= 1'b0;
        end else if (frame_done) begin
            frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
            blink     <= wrap ? ~blink : blink;
        end
    end

    assign blank_rows = blink && (status_latched == 2'b11);
`else
    assign blank_rows = 1'b0;
`endif

endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// tb_led_matrix_column_scanner: directed self-checking bench for led_matrix_column_scanner.
module tb_led_matrix_column_scanner;
    localparam int CD = 4;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int PER = CD + BC;
    localparam int FRM = 5 * PER;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  irrigation_status = 2'b00;
    logic [34:0] col_rows = '0;
    logic [1:0]  status_latched;
    logic [4:0]  columns;
    logic [6:0]  rows;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_matrix_column_scanner #(.CLK_DIV(CD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .irrigation_status(irrigation_status),
        .col_rows(col_rows),
        .status_latched(status_latched),
        .columns(columns),
        .rows(rows),
        .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_columns"}, 32'(columns), 32'h1f);
        chk({tag, "_rows"}, 32'(rows), 32'h0);
        chk({tag, "_status"}, 32'(status_latched), 32'h0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        logic [4:0] ecol;
        logic [6:0] erow;
        logic [1:0] est;
        int p, k, f;
        bit blank;

        irrigation_status = 2'($urandom);
        col_rows = {3'($urandom), $urandom};
        repeat (3) @(negedge clk);
        chk_reset("hold_reset");

        irrigation_status = 2'b01;
        for (int i = 0; i < 5; i++) col_rows[7*i +: 7] = 7'(7'h01 << i);
        rst_n = 1'b1;
        #1;
        for (int c = 1; c <= 70; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 10) irrigation_status = 2'b10;
            p = (c - 1) % PER;
            k = ((c - 1) / PER) % 5;
            blank = (p < BC);
            ecol = blank ? 5'h1f : ~(5'd1 << k);
            erow = blank ? 7'd0 : 7'(7'h01 << k);
            est = (c == 1) ? 2'b00 : (c <= FRM + 1) ? 2'b01 : 2'b10;
            chk("scan_columns", 32'(columns), 32'(ecol));
            chk("scan_rows", 32'(rows), 32'(erow));
            chk("scan_frame_done", 32'(frame_done), 32'(((c - 1) % FRM) == FRM - 1));
            chk("scan_status", 32'(status_latched), 32'(est));
        end
        chk("mid_drive_active", 32'(columns == 5'h1f), 32'h0);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_drive_reset");

`ifdef IRRIGATION_BLINK_EN
        @(negedge clk);
        irrigation_status = 2'b11;
        col_rows = '1;
        rst_n = 1'b1;
        #1;
        for (int c = 1; c <= 6 * FRM; c++) begin
            if (c > 1) @(negedge clk);
            p = (c - 1) % PER;
            k = ((c - 1) / PER) % 5;
            f = (c - 1) / FRM;
            blank = (p < BC);
            ecol = blank ? 5'h1f : ~(5'd1 << k);
            erow = (blank || ((f / 2) % 2 == 1)) ? 7'd0 : 7'h7f;
            chk("blink_columns", 32'(columns), 32'(ecol));
            chk("blink_rows", 32'(rows), 32'(erow));
        end
        @(negedge clk);
        rst_n = 1'b0;
        irrigation_status = 2'b01;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int c = 1; c <= 6 * FRM; c++) begin
            if (c > 1) @(negedge clk);
            blank = (((c - 1) % PER) < BC);
            chk("noblink_rows", 32'(rows), blank ? 32'h0 : 32'h7f);
        end
`endif

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 1000 * FRM; c++) begin
            @(negedge clk);
            irrigation_status = 2'($urandom);
            col_rows = {3'($urandom), $urandom};
            chk("inv_one_column", 32'($countones(~columns) <= 1), 32'h1);
            if (columns == 5'h1f) chk("inv_blank_rows", 32'(rows), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
